// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I memory stage: LOAD/STORE over a req/ack data bus, pass-through for other ops.
// Registered bus outputs; in_ready is low while a bus access is outstanding or its result is being presented.
module memory_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   valE,
  input  logic [XLEN-1:0]   valB,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   valM,
  output logic              fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_nxt;

  logic       accept;
  logic       bus_done;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       illegal;
  logic       misaligned;
  logic       dec_fault;
  logic [3:0] st_strb;
  logic [31:0] st_data;

  // Context captured with the request so the response can be formed from mem_rdata alone.
  logic [1:0] off_q;
  logic [2:0] f3_q;

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] ld_data;

  // ---------------------------------------------------------------- decode
  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_mem   = is_load | is_store;

    illegal = 1'b0;
    if (is_load)
      illegal = (func3 == 3'b011) || (func3[2:1] == 2'b11);
    else if (is_store)
      illegal = func3[2] || (func3 == 3'b011);

    misaligned = ((func3[1:0] == 2'b01) && valE[0]) ||
                 ((func3[1:0] == 2'b10) && (valE[1:0] != 2'b00));

    dec_fault = is_mem && (illegal || misaligned);
  end

  // Store data is replicated across lanes; the strobes pick the lane(s) actually written.
  always_comb begin
    st_strb = 4'b1111;
    st_data = valB;
    case (func3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << valE[1:0];
        st_data = {4{valB[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {valE[1], 1'b0};
        st_data = {2{valB[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = valB;
      end
    endcase
  end

  // ------------------------------------------------------- load extraction
  always_comb begin
    byte_sh = mem_rdata >> {off_q, 3'b000};
    half_sh = mem_rdata >> {off_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_data = {24'd0, byte_sh[7:0]};
      3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_data = {16'd0, half_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mem && !dec_fault) state_nxt = BUS;
      BUS:  if (mem_ack) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_valid && in_ready;
    bus_done = (state == BUS) && mem_ack;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      out_valid <= 1'b0;
      valM      <= '0;
      fault     <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          out_valid <= 1'b1;
          valM      <= valE;
          fault     <= 1'b0;
        end else if (dec_fault) begin
          out_valid <= 1'b1;
          valM      <= '0;
          fault     <= 1'b1;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= is_store;
          mem_addr  <= {valE[XLEN-1:2], 2'b00};
          mem_wdata <= is_store ? st_data : '0;
          mem_wstrb <= is_store ? st_strb : 4'b0000;
          off_q     <= valE[1:0];
          f3_q      <= func3;
        end
      end
      // The RESP cycle is exactly the cycle after the ack, so out_valid is raised here.
      if (bus_done) begin
        mem_req   <= 1'b0;
        out_valid <= 1'b1;
        fault     <= 1'b0;
        valM      <= mem_we ? '0 : ld_data;
      end
    end
  end

endmodule
